// File: rtl/dut_pkg.sv
// Shared constants for the dut register map and FIFO sizing.
package dut_pkg;

    localparam int unsigned ADDR_W             = 3;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 2;

    localparam logic [ADDR_W-1:0] ADDR_A_STATUS = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_B_STATUS = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_Y_STATUS = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_Y_DATA   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_A_DATA   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_B_DATA   = 3'd5;

endpackage

// File: rtl/dut_fifo.sv
// 1-bit synchronous FIFO with asynchronous active-high clear.
module dut_fifo #(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic enq_i,
    input  logic data_i,
    input  logic deq_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             enq_ok, deq_ok;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = empty_o ? 1'b0 : mem_q[rptr_q];

    // Full/empty are judged on pre-edge state, so a same-edge deq never makes room for an enq.
    assign enq_ok = enq_i && !full_o;
    assign deq_ok = deq_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (enq_ok) begin
            wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (deq_ok) begin
            rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
        end
        case ({enq_ok, deq_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (enq_ok) begin
                mem_q[wptr_q] <= data_i;
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/dut.sv
// Two input FIFOs feeding an OR stage into an output FIFO, behind a small register map.
module dut
    import dut_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] write_address,
    input  logic              write_data,
    input  logic              write_en,
    output logic              write_rdy,
    input  logic [ADDR_W-1:0] read_address,
    input  logic              read_en,
    output logic              read_data,
    output logic              read_rdy
);

    logic a_full, a_empty, a_head;
    logic b_full, b_empty, b_head;
    logic y_full, y_empty, y_head;
    logic a_enq, b_enq, y_deq, compute;

    // RST_N is active-high despite its name.
    assign write_rdy = !RST_N;
    assign read_rdy  = !RST_N;

    assign a_enq   = write_en && (write_address == ADDR_A_DATA);
    assign b_enq   = write_en && (write_address == ADDR_B_DATA);
    assign y_deq   = read_en && (read_address == ADDR_Y_DATA);
    assign compute = !a_empty && !b_empty && !y_full;

    dut_fifo #(.Depth(FIFO_DEPTH)) u_a_ff (
        .clk_i   (CLK),
        .clr_i   (RST_N),
        .enq_i   (a_enq),
        .data_i  (write_data),
        .deq_i   (compute),
        .full_o  (a_full),
        .empty_o (a_empty),
        .head_o  (a_head)
    );

    dut_fifo #(.Depth(FIFO_DEPTH)) u_b_ff (
        .clk_i   (CLK),
        .clr_i   (RST_N),
        .enq_i   (b_enq),
        .data_i  (write_data),
        .deq_i   (compute),
        .full_o  (b_full),
        .empty_o (b_empty),
        .head_o  (b_head)
    );

    dut_fifo #(.Depth(FIFO_DEPTH)) u_y_ff (
        .clk_i   (CLK),
        .clr_i   (RST_N),
        .enq_i   (compute),
        .data_i  (a_head | b_head),
        .deq_i   (y_deq),
        .full_o  (y_full),
        .empty_o (y_empty),
        .head_o  (y_head)
    );

    always_comb begin
        read_data = 1'b0;
        case (read_address)
            ADDR_A_STATUS: read_data = !a_full;
            ADDR_B_STATUS: read_data = !b_full;
            ADDR_Y_STATUS: read_data = !y_empty;
            ADDR_Y_DATA:   read_data = y_head;
            default:       read_data = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dut.sv
// Self-checking bench for dut: directed vector table, reset corner cases, random vs queue model.
module tb_dut;

    localparam int unsigned D = 2;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [2:0] write_address;
    logic       write_data;
    logic       write_en;
    logic       write_rdy;
    logic [2:0] read_address;
    logic       read_en;
    logic       read_data;
    logic       read_rdy;

    int total = 0;
    int bad   = 0;

    bit qa[$];
    bit qb[$];
    bit qy[$];

    typedef struct {
        bit       we;
        bit [2:0] wa;
        bit       wd;
        bit       re;
        bit [2:0] ra;
        bit       exp;
    } vec_t;

    vec_t vecs[$];

    dut #(.FIFO_DEPTH(D)) u_dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit we, input bit [2:0] wa, input bit wd, input bit re,
                         input bit [2:0] ra);
        write_en      = we;
        write_address = wa;
        write_data    = wd;
        read_en       = re;
        read_address  = ra;
    endtask

    function automatic bit model_rd(input bit [2:0] ra);
        case (ra)
            3'd0:    return qa.size() < D;
            3'd1:    return qb.size() < D;
            3'd2:    return qy.size() > 0;
            3'd3:    return (qy.size() > 0) ? qy[0] : 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one clock edge; all decisions use pre-edge occupancy.
    task automatic model_edge(input bit we, input bit [2:0] wa, input bit wd, input bit re,
                              input bit [2:0] ra);
        bit do_c, yd, a_ok, b_ok, r;
        do_c = (qa.size() > 0) && (qb.size() > 0) && (qy.size() < D);
        yd   = re && (ra == 3'd3) && (qy.size() > 0);
        a_ok = we && (wa == 3'd4) && (qa.size() < D);
        b_ok = we && (wa == 3'd5) && (qb.size() < D);
        if (yd) void'(qy.pop_front());
        if (do_c) begin
            r = qa.pop_front() | qb.pop_front();
            qy.push_back(r);
        end
        if (a_ok) qa.push_back(wd);
        if (b_ok) qb.push_back(wd);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        drive(0, 0, 0, 0, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        qa.delete();
        qb.delete();
        qy.delete();
    endtask

    task automatic add(input bit we, input bit [2:0] wa, input bit wd, input bit re,
                       input bit [2:0] ra, input bit exp);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        RST_N = 1'b1;
        drive(0, 0, 0, 0, 0);
        #2;
        check("rst_write_rdy", write_rdy, 1'b0);
        check("rst_read_rdy", read_rdy, 1'b0);
        do_reset();
        #1;
        check("post_rst_write_rdy", write_rdy, 1'b1);
        check("post_rst_read_rdy", read_rdy, 1'b1);

        // Directed table: each row is driven before an edge and read_data checked pre-edge.
        add(0, 0, 0, 0, 0, 1);  // A not full
        add(0, 0, 0, 0, 1, 1);  // B not full
        add(0, 0, 0, 0, 2, 0);  // Y empty
        add(0, 0, 0, 0, 3, 0);
        add(1, 4, 1, 0, 2, 0);  // A=1
        add(1, 5, 0, 0, 0, 1);  // B=0
        add(0, 0, 0, 0, 2, 0);  // compute at this edge
        add(0, 0, 0, 0, 2, 1);
        add(0, 0, 0, 1, 3, 1);  // dequeue 1|0
        add(0, 0, 0, 0, 2, 0);
        add(1, 4, 0, 0, 2, 0);  // pair (0,0)
        add(1, 5, 0, 0, 2, 0);
        add(1, 4, 0, 0, 2, 0);  // pair (0,1), first pair computes
        add(1, 5, 1, 0, 2, 1);
        add(1, 4, 1, 0, 2, 1);  // pair (1,0)
        add(1, 5, 0, 0, 2, 1);
        add(1, 4, 1, 0, 1, 1);  // pair (1,1), Y full so A backs up
        add(1, 5, 1, 0, 0, 0);  // A full
        add(1, 4, 0, 0, 1, 0);  // A full -> dropped; B full
        add(0, 0, 0, 1, 3, 0);  // Y: 0
        add(0, 0, 0, 1, 3, 1);  // Y: 1
        add(0, 0, 0, 1, 3, 1);  // Y: 1|0
        add(0, 0, 0, 1, 3, 1);  // Y: 1|1
        add(0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 0, 1);
        add(1, 6, 1, 0, 7, 0);  // ignored write, addr 7 reads 0
        add(1, 3, 1, 1, 2, 0);
        add(0, 0, 0, 0, 1, 1);

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
            #1;
            check($sformatf("vec%0d", i), read_data, vecs[i].exp);
        end

        // A written three times with no B: third is dropped, then two B writes drain A.
        do_reset();
        @(negedge CLK); drive(1, 4, 1, 0, 0);
        @(negedge CLK); drive(1, 4, 0, 0, 0);
        @(negedge CLK); drive(1, 4, 1, 0, 0); #1;
        check("a_full_after_two", read_data, 1'b0);
        @(negedge CLK); drive(1, 5, 0, 0, 0);
        @(negedge CLK); drive(1, 5, 0, 0, 3);
        @(negedge CLK); drive(0, 0, 0, 1, 3); #1;
        check("a3_y0", read_data, 1'b1);
        @(negedge CLK); drive(0, 0, 0, 1, 3); #1;
        check("a3_y1", read_data, 1'b0);
        @(negedge CLK); drive(0, 0, 0, 0, 2); #1;
        check("a3_drop_empty", read_data, 1'b0);

        // Async reset mid-stream with data in A, B and Y.
        do_reset();
        @(negedge CLK); drive(1, 4, 1, 0, 0);
        @(negedge CLK); drive(1, 5, 1, 0, 0);
        @(negedge CLK); drive(1, 4, 0, 0, 0);
        @(negedge CLK); drive(1, 5, 0, 0, 0);
        @(negedge CLK); drive(0, 0, 0, 0, 2); #1;
        check("pre_rst_y_nonempty", read_data, 1'b1);
        #2;
        RST_N = 1'b1;
        #1;
        check("mid_rst_write_rdy", write_rdy, 1'b0);
        check("mid_rst_read_rdy", read_rdy, 1'b0);
        check("mid_rst_y_status", read_data, 1'b0);
        read_address = 3'd0; #1;
        check("mid_rst_a_status", read_data, 1'b1);
        read_address = 3'd1; #1;
        check("mid_rst_b_status", read_data, 1'b1);
        @(negedge CLK); drive(1, 6, 1, 1, 1);
        @(negedge CLK); drive(1, 4, 1, 1, 3);
        @(negedge CLK); drive(0, 0, 0, 0, 3);
        RST_N = 1'b0;
        qa.delete(); qb.delete(); qy.delete();
        #1;
        check("rel_y_data", read_data, 1'b0);
        @(negedge CLK); drive(0, 0, 0, 0, 0); #1;
        check("rel_a_status", read_data, 1'b1);
        @(negedge CLK); drive(0, 0, 0, 0, 2); #1;
        check("rel_y_status", read_data, 1'b0);

        // Random traffic against the queue model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit       we, wd, re;
            bit [2:0] wa, ra;
            we = ($urandom_range(0, 3) != 0);
            wa = 3'($urandom_range(3, 7));
            wd = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 2) == 0);
            ra = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ra = 3'd3;
            @(negedge CLK);
            drive(we, wa, wd, re, ra);
            #1;
            check($sformatf("rnd%0d_ra%0d", i, ra), read_data, model_rd(ra));
            if (i % 50 == 0) check("rnd_rdy", write_rdy & read_rdy, 1'b1);
            model_edge(we, wa, wd, re, ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dut.md
DUT -- requirements
Module: dut

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, entries in each of the A, B and Y FIFOs.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-high (asserted = 1) despite the name.
REQ-004 write_address  input  3  target of a write.
REQ-005 write_data  input  1  bit to write.
REQ-006 write_en  input  1  write strobe, sampled on rising CLK.
REQ-007 write_rdy  output  1  write accept indication.
REQ-008 read_address  input  3  register selected for read.
REQ-009 read_en  input  1  read strobe; the only side effect is a Y dequeue at address 3.
REQ-010 read_data  output  1  selected register value.
REQ-011 read_rdy  output  1  read accept indication.

Function
REQ-012 Three 1-bit FIFOs of FIFO_DEPTH: A_ff and B_ff (inputs), Y_ff (output).
REQ-013 write_rdy and read_rdy SHALL be 1 whenever reset is deasserted and 0 while reset is asserted.
REQ-014 Write with write_en=1, address 4: enqueue write_data into A_ff if not full, else drop silently.
REQ-015 Write with write_en=1, address 5: enqueue write_data into B_ff if not full, else drop silently.
REQ-016 Writes to addresses 0-3, 6 and 7 SHALL be ignored.
REQ-017 read_data is combinational from read_address and FIFO state:
- addr 0: A_ff not full.
- addr 1: B_ff not full.
- addr 2: Y_ff not empty.
- addr 3: head of Y_ff, or 0 if empty.
- addrs 4-7: 0.
REQ-018 Address 3 with read_en=1 and Y_ff not empty SHALL dequeue Y_ff at that edge; if empty, no state change.
REQ-019 read_en at other addresses SHALL have no side effect.
REQ-020 Compute: at an edge where A_ff and B_ff are both non-empty and Y_ff is not full, dequeue both and enqueue (A head OR B head) into Y_ff.
REQ-021 Compute latency: operands present before edge N give the result visible at address 3/2 after edge N; a write at edge N reaches Y no earlier than edge N+1.
REQ-022 Same-edge enqueue and dequeue on one FIFO SHALL both take effect; count unchanged.
- On a full Y_ff, a same-edge dequeue does not free space for a same-edge compute.
- On an empty A/B FIFO, a same-edge write is not consumed by a same-edge compute.
REQ-023 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; order is strictly FIFO.

Reset
REQ-024 RST_N=1 SHALL immediately, without waiting for CLK, empty all FIFOs and force write_rdy=0 and read_rdy=0.
- read_data SHALL follow REQ-017 for empty FIFOs: addr 0/1 = 1, addr 2/3 = 0.
REQ-025 Reset asserted mid-operation discards all queued data; no partial compute completes.

Structure
REQ-026 Shared package dut_pkg: address constants ADDR_A_STATUS=0, ADDR_B_STATUS=1, ADDR_Y_STATUS=2, ADDR_Y_DATA=3, ADDR_A_DATA=4, ADDR_B_DATA=5, and default FIFO_DEPTH.
REQ-027 One sub-module dut_fifo: parameterised-depth 1-bit synchronous FIFO with enq/deq/full/empty/head ports and async active-high clear; instantiated three times.

Verification
REQ-028 Reset then read addrs 0,1,2,3 -> 1,1,0,0; write_rdy=read_rdy=1 after release.
REQ-029 Write A=1 (addr 4), B=0 (addr 5), wait 2 cycles -> addr 2 reads 1, addr 3 reads 1; read_en at addr 3 -> addr 2 reads 0.
REQ-030 Sweep all four (A,B) pairs -> Y = 0,1,1,1 in order.
REQ-031 Write A three times with no B -> addr 0 reads 0 after second write, third write dropped; then 2 B writes -> 2 Y results matching the first two A values.
REQ-032 Fill Y (2 results) plus 2 more A/B pairs without reading -> A/B stay full; each Y dequeue lets one queued pair compute on the next edge, order preserved.
REQ-033 Assert RST_N mid-stream with data in all FIFOs -> status reads 1,1,0 immediately; write to addr 6 and read_en at addr 1 -> no state change.
